// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, runs the req/ack read to
// instruction memory and hands each fetched word to the instruction Register.
module fetch_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              ir_load,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_out
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DELIVER
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              redirect_pending;
  logic [ADDR_W-1:0] redirect_target;

  assign mem_req  = (state == REQ);
  assign ir_load  = (state == DELIVER);
  assign mem_addr = pc;
  assign pc_out   = pc;

  // A branch seen while a read is in flight cannot move the address bus, so it
  // is remembered and applied (with the returned word dropped) once ack arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      ir_data          <= '0;
      instr_pc         <= '0;
      redirect_pending <= 1'b0;
      redirect_target  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_en) begin
            pc <= branch_addr;
          end
          if (!stall) begin
            state <= REQ;
          end
        end

        REQ: begin
          if (mem_ack) begin
            if (branch_en) begin
              pc               <= branch_addr;
              redirect_pending <= 1'b0;
              state            <= IDLE;
            end else if (redirect_pending) begin
              pc               <= redirect_target;
              redirect_pending <= 1'b0;
              state            <= IDLE;
            end else begin
              ir_data  <= mem_rdata;
              instr_pc <= pc;
              pc       <= pc + PC_STEP;
              state    <= DELIVER;
            end
          end else if (branch_en) begin
            redirect_pending <= 1'b1;
            redirect_target  <= branch_addr;
          end
        end

        DELIVER: begin
          // The word is still pulsed out; squashing it belongs to the control path.
          if (branch_en) begin
            pc <= branch_addr;
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed fetch scenarios with a scoreboard
// of expected {word, address} deliveries checked on every ir_load pulse.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        branch_en;
  logic [15:0] branch_addr;
  logic        ir_load;
  logic [15:0] ir_data;
  logic [15:0] instr_pc;
  logic [15:0] pc_out;

  // Second instance starts at the top of memory and is always acked at once.
  logic        mem_req2;
  logic [15:0] mem_addr2;
  logic        ir_load2;
  logic [15:0] ir_data2;
  logic [15:0] instr_pc2;
  logic [15:0] pc_out2;
  logic        mem_ack2;
  logic [15:0] no_branch;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .branch_en(branch_en), .branch_addr(branch_addr),
    .ir_load(ir_load), .ir_data(ir_data), .instr_pc(instr_pc), .pc_out(pc_out)
  );

  assign mem_ack2  = mem_req2;
  assign no_branch = 16'h0000;

  fetch_unit #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(reset),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack2), .mem_rdata(16'h1234),
    .stall(1'b0), .branch_en(1'b0), .branch_addr(no_branch),
    .ir_load(ir_load2), .ir_data(ir_data2), .instr_pc(instr_pc2), .pc_out(pc_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return (a == 16'h0000) ? 16'haa11 : (a ^ 16'hc3c3);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Called with the DUT in REQ at addr; acks after ackDelay waiting cycles.
  task automatic applyStimulus(input int ackDelay, input logic [15:0] addr);
    for (int i = 0; i < ackDelay; i++) begin
      checkOutput("wait_req", 32'(mem_req), 32'd1);
      checkOutput("wait_addr", 32'(mem_addr), 32'(addr));
      nextCycle();
    end
    checkOutput("ack_req", 32'(mem_req), 32'd1);
    checkOutput("ack_addr", 32'(mem_addr), 32'(addr));
    mem_ack   = 1'b1;
    mem_rdata = memWord(addr);
    exp_q.push_back({memWord(addr), addr});
    nextCycle();
    mem_ack = 1'b0;
    checkOutput("dlv_load", 32'(ir_load), 32'd1);
    checkOutput("dlv_pc", 32'(pc_out), 32'(addr + 16'h0001));
  endtask

  // Scoreboard: every ir_load pulse must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (ir_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_load", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checkOutput("sb_ir_data", 32'(ir_data), 32'(e[31:16]));
        checkOutput("sb_instr_pc", 32'(instr_pc), 32'(e[15:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    mem_ack     = 1'b0;
    mem_rdata   = 16'h0000;
    stall       = 1'b0;
    branch_en   = 1'b0;
    branch_addr = 16'h0000;
    nextCycle();
    nextCycle();
    checkOutput("rst_req", 32'(mem_req), 32'd0);
    checkOutput("rst_load", 32'(ir_load), 32'd0);
    checkOutput("rst_addr", 32'(mem_addr), 32'h0000);
    checkOutput("rst_pc", 32'(pc_out), 32'h0000);
    checkOutput("rst_ir", 32'(ir_data), 32'h0000);
    checkOutput("rst_ipc", 32'(instr_pc), 32'h0000);
    checkOutput("rst_pc_wrap", 32'(pc_out2), 32'hFFFF);

    // Basic fetch from reset with an immediate ack
    reset = 1'b0;
    nextCycle();
    applyStimulus(0, 16'h0000);
    checkOutput("first_ir", 32'(ir_data), 32'haa11);
    checkOutput("wrap_load", 32'(ir_load2), 32'd1);
    checkOutput("wrap_ipc", 32'(instr_pc2), 32'hFFFF);
    checkOutput("wrap_pc", 32'(pc_out2), 32'h0000);
    checkOutput("wrap_ir", 32'(ir_data2), 32'h1234);

    // Branch from IDLE to 0005, then a 3-cycle ack delay
    nextCycle();
    checkOutput("idle_req", 32'(mem_req), 32'd0);
    branch_en   = 1'b1;
    branch_addr = 16'h0005;
    nextCycle();
    branch_en = 1'b0;
    applyStimulus(3, 16'h0005);

    // Branch to 0040 two cycles before ack: word dropped, refetch from 0040
    nextCycle();
    nextCycle();
    checkOutput("req6_addr", 32'(mem_addr), 32'h0006);
    branch_en   = 1'b1;
    branch_addr = 16'h0040;
    nextCycle();
    branch_en = 1'b0;
    checkOutput("redir_hold1", 32'(mem_addr), 32'h0006);
    nextCycle();
    checkOutput("redir_hold2", 32'(mem_addr), 32'h0006);
    mem_ack   = 1'b1;
    mem_rdata = memWord(16'h0006);
    nextCycle();
    mem_ack = 1'b0;
    checkOutput("drop_load", 32'(ir_load), 32'd0);
    checkOutput("drop_req", 32'(mem_req), 32'd0);
    checkOutput("drop_pc", 32'(pc_out), 32'h0040);
    checkOutput("drop_ir_kept", 32'(ir_data), 32'(memWord(16'h0005)));
    nextCycle();
    checkOutput("refetch_req", 32'(mem_req), 32'd1);
    checkOutput("refetch_addr", 32'(mem_addr), 32'h0040);

    // Latched target 0090 overridden by a same-cycle branch to 00A0 on ack
    branch_en   = 1'b1;
    branch_addr = 16'h0090;
    nextCycle();
    branch_addr = 16'h00A0;
    mem_ack     = 1'b1;
    mem_rdata   = memWord(16'h0040);
    nextCycle();
    mem_ack   = 1'b0;
    branch_en = 1'b0;
    checkOutput("override_load", 32'(ir_load), 32'd0);
    checkOutput("override_pc", 32'(pc_out), 32'h00A0);
    nextCycle();
    applyStimulus(0, 16'h00A0);

    // Stall held four cycles in IDLE
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("stall_req", 32'(mem_req), 32'd0);
    end
    stall = 1'b0;
    nextCycle();
    checkOutput("unstall_req", 32'(mem_req), 32'd1);

    // Stall rising during REQ does not abort the fetch
    stall = 1'b1;
    applyStimulus(2, 16'h00A1);
    stall = 1'b0;

    // Asynchronous reset in the middle of a REQ
    nextCycle();
    nextCycle();
    checkOutput("pre_rst_req", 32'(mem_req), 32'd1);
    checkOutput("pre_rst_addr", 32'(mem_addr), 32'h00A2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_req", 32'(mem_req), 32'd0);
    checkOutput("async_load", 32'(ir_load), 32'd0);
    checkOutput("async_ir", 32'(ir_data), 32'h0000);
    checkOutput("async_pc", 32'(pc_out), 32'h0000);
    nextCycle();
    reset = 1'b0;
    nextCycle();
    applyStimulus(1, 16'h0000);
    nextCycle();
    nextCycle();

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
